monitor_dmem_wr: RTL and testbench

Avalon-MM slave in the monitor Qsys system that lets the host monitor write one word into the tinymips data memory. The monitor loads a data word and a memory address into register slots, then issues a GO command. The block drives a single request/acknowledge transaction on the data-memory side and reports busy, done, error and a completed-write count back over the same slave.

---
 rtl/monitor_dmem_wr.sv | 149 ++++++++++++++
 tb/tb_monitor_dmem_wr.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/monitor_dmem_wr.sv
// Avalon-MM slave that lets the monitor host write a single word into the
// tinymips data memory through a one-shot request/acknowledge handshake.
module monitor_dmem_wr #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_req,
    input  logic              mem_ack
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]     count_q;
    logic [TW-1:0]   tmo_cnt;
    logic            done_q, err_q;
    logic            busy;

    logic wr_en, wr_data, wr_addr, wr_ctrl, wr_count;
    logic go, clr;
    logic start, ack_done, tmo_hit;

    assign wr_en    = chipselect & ~write_n;
    assign wr_data  = wr_en && (address == 2'd0);
    assign wr_addr  = wr_en && (address == 2'd1);
    assign wr_ctrl  = wr_en && (address == 2'd2);
    assign wr_count = wr_en && (address == 2'd3);
    assign go       = wr_ctrl & writedata[0];
    assign clr      = wr_ctrl & writedata[1];

    // mem_req is decoded straight from the state register so an asynchronous
    // reset drops it immediately rather than at the next edge.
    assign busy      = (state_q == REQ);
    assign mem_req   = busy;
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        ack_done = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = REQ;
                    start   = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d  = IDLE;
                    ack_done = 1'b1;
                end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
                    state_d = IDLE;
                    tmo_hit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            addr_q <= '0;
        end else if (!busy) begin
            if (wr_data) data_q <= writedata;
            if (wr_addr) addr_q <= writedata[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (start) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (ack_done) begin
            done_q <= 1'b1;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end else if (clr && !busy) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (start) begin
            tmo_cnt <= '0;
        end else if (busy && (TIMEOUT != 0)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A software clear takes priority over an increment on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (wr_count) begin
            count_q <= '0;
        end else if (ack_done) begin
            count_q <= count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= data_q;
                2'd1:    readdata <= 32'(addr_q);
                2'd2:    readdata <= {29'b0, err_q, done_q, busy};
                default: readdata <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_monitor_dmem_wr.sv
// Randomized bench for monitor_dmem_wr, checked against a register-level
// model of the monitor's view (DATA/ADDR/STATUS/COUNT and transfer length).
module tb_monitor_dmem_wr;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req;
    logic        mem_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_data, m_count;
    logic [7:0]  m_addr;
    logic        m_done, m_err;

    monitor_dmem_wr #(.ADDR_W(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic av_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        step();
        check_eq(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic model_reset();
        m_data = '0; m_addr = '0; m_count = '0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_all();
        av_read(2'd0, m_data, "rd_data");
        av_read(2'd1, {24'b0, m_addr}, "rd_addr");
        av_read(2'd2, {29'b0, m_err, m_done, 1'b0}, "rd_status");
        av_read(2'd3, m_count, "rd_count");
        check_eq("mem_wdata", mem_wdata, m_data);
        check_eq("mem_addr", {24'b0, mem_addr}, {24'b0, m_addr});
    endtask

    // ack_at = 0 means the memory never answers.
    task automatic run_xfer(input int ack_at, input bit clr_cnt_at_ack, input bit lock_wr);
        int    req_cycles;
        int    exp_cycles;
        bit    acked;
        bit    c;
        c = 1'($urandom_range(0, 1));
        av_write(2'd2, {30'b0, c, 1'b1});
        m_done = 1'b0; m_err = 1'b0;
        acked = (ack_at != 0) && (ack_at <= int'(TMO));
        exp_cycles = acked ? ack_at : int'(TMO);
        req_cycles = 0;
        for (int cyc = 1; cyc <= 20 && mem_req; cyc++) begin
            req_cycles++;
            check_eq("hold_wdata", mem_wdata, m_data);
            check_eq("hold_addr", {24'b0, mem_addr}, {24'b0, m_addr});
            if (cyc == ack_at) mem_ack = 1'b1;
            if (cyc == ack_at && clr_cnt_at_ack) begin
                address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
            end else if (cyc == 1 && lock_wr) begin
                address = 2'($urandom_range(0, 2)); chipselect = 1'b1; write_n = 1'b0;
                writedata = $urandom | 32'd1;
            end
            step();
            mem_ack = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        end
        check_eq("req_cycles", req_cycles, exp_cycles);
        check_eq("req_low_after", {31'b0, mem_req}, 32'd0);
        if (acked) begin
            m_done  = 1'b1;
            m_count = clr_cnt_at_ack ? 32'd0 : m_count + 32'd1;
        end else begin
            m_err = 1'b1;
        end
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (3) step();
        check_eq("rst_req", {31'b0, mem_req}, 32'd0);
        check_eq("rst_rdata", readdata, 32'd0);
        reset_n = 1'b1;
        step();
        check_all();

        // Basic transfer, busy lockout, timeout, late ack, CLR, collision.
        av_write(2'd0, 32'hDEADBEEF); m_data = 32'hDEADBEEF;
        av_write(2'd1, 32'h0000002A); m_addr = 8'h2A;
        run_xfer(3, 1'b0, 1'b0);
        run_xfer(2, 1'b0, 1'b1);
        run_xfer(0, 1'b0, 1'b0);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        check_eq("late_ack_req", {31'b0, mem_req}, 32'd0);
        check_all();
        av_write(2'd2, 32'h2); m_done = 1'b0; m_err = 1'b0;
        check_all();
        run_xfer(4, 1'b0, 1'b0);
        run_xfer(1, 1'b1, 1'b0);

        // COUNT wrap via back-door deposit.
        dut.count_q = 32'hFFFF_FFFF; m_count = 32'hFFFF_FFFF;
        av_read(2'd3, m_count, "cnt_deposit");
        run_xfer(2, 1'b0, 1'b0);

        // Reset in the middle of a request.
        av_write(2'd2, 32'h1);
        step();
        reset_n = 1'b0;
        #1;
        check_eq("midrst_req", {31'b0, mem_req}, 32'd0);
        check_eq("midrst_wdata", mem_wdata, 32'd0);
        step();
        reset_n = 1'b1;
        model_reset();
        step();
        check_all();

        for (int i = 0; i < 40; i++) begin
            int op;
            logic [31:0] d;
            op = int'($urandom_range(0, 5));
            d = $urandom;
            case (op)
                0: begin av_write(2'd0, d); m_data = d; end
                1: begin av_write(2'd1, d); m_addr = d[7:0]; end
                2: begin av_write(2'd2, {d[31:2], 1'b1, 1'b0}); m_done = 1'b0; m_err = 1'b0; end
                3: begin av_write(2'd3, d); m_count = '0; end
                4: check_all();
                default: run_xfer(int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0),
                                  1'($urandom_range(0, 1)));
            endcase
        end
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
